// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter: state encodings,
// default limits and fixed counter widths.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2,
    ST_ERR   = 2'd3
  } arb_state_e;

  localparam int DEF_MAX_DM_BURST = 3;
  localparam int DEF_TIMEOUT      = 255;
  localparam int STREAK_W         = 4;
  localparam int WDOG_W           = 8;

endpackage

// File: rtl/arb_wdog.sv
// Access watchdog: counts cycles a granted access waits on the memory and flags
// the cycle in which the wait reaches LIMIT.
module arb_wdog #(
  parameter int CW    = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic tick,
  output logic expired
);

  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     cnt <= '0;
    else if (clr)                 cnt <= '0;
    else if (tick && cnt != LAST) cnt <= cnt + 1'b1;
  end

  // Fires on the LIMIT-th waiting cycle itself so the FSM can leave on that edge.
  assign expired = tick && (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between instruction
// fetch and the data port; raises the global stall and a sticky hang error.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int MAX_DM_BURST = DEF_MAX_DM_BURST,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          dm_req,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          stall,
  output logic          err
);

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_BURST);

  arb_state_e          state, state_n;
  acc_t                lat;
  logic [STREAK_W-1:0] streak;
  logic                grant_if, grant_dm, busy, expired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    case (state)
      ST_IDLE: begin
        // Data normally wins; a waiting fetch takes over once the data streak is spent.
        if (dm_req && (streak < STREAK_MAX || !if_req)) begin
          grant_dm = 1'b1;
          state_n  = ST_DATA;
        end else if (if_req) begin
          grant_if = 1'b1;
          state_n  = ST_FETCH;
        end
      end
      ST_FETCH, ST_DATA: begin
        if (mem_ready)    state_n = ST_IDLE;
        else if (expired) state_n = ST_ERR;
      end
      ST_ERR:  state_n = ST_ERR;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          lat <= '0;
    else if (grant_dm) lat <= '{wr: dm_wr, addr: dm_addr, wdata: dm_wdata};
    else if (grant_if) lat <= '{wr: 1'b0, addr: if_addr, wdata: '0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              streak <= '0;
    else if (if_done)                      streak <= '0;
    else if (dm_done && streak < STREAK_MAX) streak <= streak + 1'b1;
  end

  assign busy = (state == ST_FETCH) || (state == ST_DATA);

  arb_wdog #(.CW(WDOG_W), .LIMIT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (grant_if | grant_dm),
    .tick    (busy & ~mem_ready),
    .expired (expired)
  );

  always_comb begin
    if_done   = (state == ST_FETCH) && mem_ready;
    dm_done   = (state == ST_DATA)  && mem_ready;
    if_rdata  = if_done ? mem_rdata : '0;
    dm_rdata  = dm_done ? mem_rdata : '0;
    mem_en    = busy;
    mem_wr    = (state == ST_DATA) && lat.wr;
    mem_addr  = lat.addr;
    mem_wdata = lat.wdata;
    err       = (state == ST_ERR);
    // Reset forces every output low, even with requesters still asserting.
    stall     = rst && ((state == ST_ERR) || (if_req && !if_done) || (dm_req && !dm_done));
  end

`ifndef SYNTHESIS
  a_if_hold: assert property (@(posedge clk) disable iff (!rst)
    (state == ST_FETCH) |-> (if_req && if_addr == lat.addr));
  a_dm_hold: assert property (@(posedge clk) disable iff (!rst)
    (state == ST_DATA) |-> (dm_req && dm_addr == lat.addr && dm_wr == lat.wr));
`endif

endmodule
